// File: rtl/pwr_pkg.sv
// Shared types and defaults for the high-voltage-domain handshake receiver.
package pwr_pkg;

  typedef enum logic {
    PWR_RX_IDLE = 1'b0,
    PWR_RX_ACK  = 1'b1
  } pwr_rx_state_e;

  localparam int unsigned PWR_SYNC_STAGES_DEF = 2;
  localparam int unsigned PWR_DATA_W_DEF      = 8;
  localparam int unsigned PWR_DEPTH_DEF       = 4;

endpackage : pwr_pkg

// File: rtl/pwr_sync_cell.sv
// Multi-flop synchroniser for a single asynchronous level; the only CDC-waived flops.
module pwr_sync_cell #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the async input through the chain.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchroniser flops, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule : pwr_sync_cell

// File: rtl/pwr_ls_handshake_receiver.sv
// Receives level-shifted words via a 4-phase req/ack handshake and buffers them
// in a small FIFO presented as a valid/ready stream; isolation masks the source.
module pwr_ls_handshake_receiver
  import pwr_pkg::*;
#(
  parameter int unsigned DATA_W      = PWR_DATA_W_DEF,
  parameter int unsigned DEPTH       = PWR_DEPTH_DEF,
  parameter int unsigned SYNC_STAGES = PWR_SYNC_STAGES_DEF
) (
  input  logic                      clk_high_voltage,
  input  logic                      rst,
  input  logic                      iso_en,
  input  logic                      ls_req,
  input  logic [DATA_W-1:0]         ls_data,
  output logic                      ls_ack,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      iso_abort,
  input  logic                      clr_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  pwr_rx_state_e     state_q, state_d;
  logic              iso_abort_q, iso_abort_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  level_q, level_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic req_s;
  logic req_v;
  logic full;
  logic push;
  logic pop;

  pwr_sync_cell #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (clk_high_voltage),
    .rst (rst),
    .d   (ls_req),
    .q   (req_s)
  );

  // Isolation masks the synchronised request; full uses the registered level.
  always_comb begin
    req_v = req_s & ~iso_en;
    full  = (level_q == PTR_W'(DEPTH));
    pop   = out_valid_q & out_ready;
  end

  // Handshake FSM: capture in IDLE, hold ack until req drops or isolation hits.
  always_comb begin
    state_d     = state_q;
    push        = 1'b0;
    iso_abort_d = iso_abort_q;
    if (clr_err) begin
      iso_abort_d = 1'b0;
    end
    case (state_q)
      PWR_RX_IDLE: begin
        if (req_v && !full) begin
          push    = 1'b1;
          state_d = PWR_RX_ACK;
        end
      end
      PWR_RX_ACK: begin
        if (iso_en) begin
          state_d     = PWR_RX_IDLE;
          iso_abort_d = 1'b1;
        end else if (!req_s) begin
          state_d = PWR_RX_IDLE;
        end
      end
      default: state_d = PWR_RX_IDLE;
    endcase
  end

  // FIFO pointer/level update and registered head word.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    level_d    = level_q + PTR_W'(push) - PTR_W'(pop);
    out_data_d = out_data_q;
    if (push) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = ls_data;
    end
    out_valid_d = (level_d != '0);
    // Head changes on a pop or when the first word lands in an empty FIFO;
    // a head slot that is being written this cycle bypasses from ls_data.
    if ((level_d != '0) && (pop || (level_q == '0))) begin
      if (rd_ptr_d == wr_ptr_q) begin
        out_data_d = ls_data;
      end else begin
        out_data_d = mem_q[rd_ptr_d[IDX_W-1:0]];
      end
    end
  end

  // State, FIFO and output registers.
  always_ff @(posedge clk_high_voltage or posedge rst) begin
    if (rst) begin
      state_q     <= PWR_RX_IDLE;
      iso_abort_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      mem_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      iso_abort_q <= iso_abort_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      mem_q       <= mem_d;
    end
  end

  assign ls_ack     = (state_q == PWR_RX_ACK);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign fifo_level = level_q;
  assign iso_abort  = iso_abort_q;

endmodule : pwr_ls_handshake_receiver

// File: tb/tb_pwr_ls_handshake_receiver.sv
// Self-checking bench for pwr_ls_handshake_receiver (DATA_W=8, DEPTH=4, SYNC_STAGES=2).
module tb_pwr_ls_handshake_receiver;

  localparam int TMO = 50;

  logic       clk_high_voltage;
  logic       rst;
  logic       iso_en;
  logic       ls_req;
  logic [7:0] ls_data;
  logic       ls_ack;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] fifo_level;
  logic       iso_abort;
  logic       clr_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic [7:0] data;
    int         exp_ack_lat;
    int         exp_rel_lat;
    logic       exp_valid;
  } vec_t;

  pwr_ls_handshake_receiver dut (
    .clk_high_voltage (clk_high_voltage),
    .rst              (rst),
    .iso_en           (iso_en),
    .ls_req           (ls_req),
    .ls_data          (ls_data),
    .ls_ack           (ls_ack),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_ready        (out_ready),
    .fifo_level       (fifo_level),
    .iso_abort        (iso_abort),
    .clr_err          (clr_err)
  );

  initial clk_high_voltage = 1'b0;
  always #5 clk_high_voltage = ~clk_high_voltage;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: scoreboard the stream at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    logic [7:0] exp;
    @(negedge clk_high_voltage);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected nothing at %0t", out_data, $time);
      end else begin
        exp = sb.pop_front();
        chk("out_data_order", 32'(out_data), 32'(exp));
      end
    end
    @(posedge clk_high_voltage);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ack(input logic val, output int lat);
    lat = 0;
    while (ls_ack !== val && lat < TMO) begin
      tick();
      lat++;
    end
    chk("ack_wait", 32'(ls_ack), 32'(val));
  endtask

  task automatic send_word(input logic [7:0] d, output int ack_lat, output int rel_lat);
    ls_data = d;
    ls_req  = 1'b1;
    sb.push_back(d);
    wait_ack(1'b1, ack_lat);
    ls_req = 1'b0;
    wait_ack(1'b0, rel_lat);
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((fifo_level !== 3'd0 || out_valid !== 1'b0) && n < TMO) begin
      tick();
      n++;
    end
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vec_t vecs [4];
    int   al, rl;

    vecs[0] = '{data: 8'hA5, exp_ack_lat: 3, exp_rel_lat: 3, exp_valid: 1'b1};
    vecs[1] = '{data: 8'h00, exp_ack_lat: 3, exp_rel_lat: 3, exp_valid: 1'b1};
    vecs[2] = '{data: 8'hFF, exp_ack_lat: 3, exp_rel_lat: 3, exp_valid: 1'b1};
    vecs[3] = '{data: 8'h5A, exp_ack_lat: 3, exp_rel_lat: 3, exp_valid: 1'b1};

    rst = 1'b1; iso_en = 1'b0; ls_req = 1'b0; ls_data = 8'h00;
    out_ready = 1'b0; clr_err = 1'b0;
    ticks(2);
    chk("rst_ls_ack", 32'(ls_ack), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_iso_abort", 32'(iso_abort), 32'd0);
    rst = 1'b0;
    ticks(2);

    // Single-word handshakes over a table of data patterns.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ls_data = vecs[i].data;
      ls_req  = 1'b1;
      sb.push_back(vecs[i].data);
      wait_ack(1'b1, al);
      chk("ack_latency", 32'(al), 32'(vecs[i].exp_ack_lat));
      chk("valid_with_ack", 32'(out_valid), 32'(vecs[i].exp_valid));
      chk("head_with_ack", 32'(out_data), 32'(vecs[i].data));
      ls_req = 1'b0;
      wait_ack(1'b0, rl);
      chk("release_latency", 32'(rl), 32'(vecs[i].exp_rel_lat));
      ticks(2);
    end
    chk("single_level", 32'(fifo_level), 32'd0);

    // Backpressure: four words fill the FIFO, the fifth ack is withheld.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_word(8'(i), al, rl);
    chk("bp_full_level", 32'(fifo_level), 32'd4);
    ls_data = 8'h05;
    ls_req  = 1'b1;
    sb.push_back(8'h05);
    ticks(10);
    chk("bp_ack_withheld", 32'(ls_ack), 32'd0);
    chk("bp_level_held", 32'(fifo_level), 32'd4);
    out_ready = 1'b1;
    wait_ack(1'b1, al);
    chk("bp_ack_after_pop", 32'(al), 32'd2);
    ls_req = 1'b0;
    wait_ack(1'b0, rl);
    drain();

    // Isolation held: request is ignored entirely.
    out_ready = 1'b0;
    iso_en  = 1'b1;
    ls_data = 8'h3C;
    ls_req  = 1'b1;
    ticks(8);
    chk("iso_no_ack", 32'(ls_ack), 32'd0);
    chk("iso_level", 32'(fifo_level), 32'd0);
    chk("iso_no_abort", 32'(iso_abort), 32'd0);
    ls_req = 1'b0;
    ticks(4);
    iso_en = 1'b0;
    ticks(2);
    chk("iso_level_after", 32'(fifo_level), 32'd0);

    // Abort in ACK, with clr_err in the same cycle: set must win.
    ls_data = 8'h5A;
    ls_req  = 1'b1;
    sb.push_back(8'h5A);
    wait_ack(1'b1, al);
    iso_en  = 1'b1;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("abort_ack_low", 32'(ls_ack), 32'd0);
    chk("abort_sticky_set_wins", 32'(iso_abort), 32'd1);
    chk("abort_word_valid", 32'(out_valid), 32'd1);
    chk("abort_word_data", 32'(out_data), 32'h5A);
    ls_req = 1'b0;
    ticks(4);
    chk("abort_still_set", 32'(iso_abort), 32'd1);
    iso_en = 1'b0;
    ticks(1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("abort_cleared", 32'(iso_abort), 32'd0);
    drain();

    // Simultaneous push and pop at level 2 across pointer wrap.
    out_ready = 1'b0;
    send_word(8'hC0, al, rl);
    send_word(8'hC1, al, rl);
    chk("pp_prefill", 32'(fifo_level), 32'd2);
    for (int i = 0; i < 12; i++) begin
      ls_data = 8'(8'h10 + i);
      ls_req  = 1'b1;
      sb.push_back(ls_data);
      ticks(2);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pp_ack", 32'(ls_ack), 32'd1);
      chk("pp_level", 32'(fifo_level), 32'd2);
      ls_req = 1'b0;
      wait_ack(1'b0, rl);
    end
    drain();

    // Async reset in ACK with level 3: outputs clear without a clock edge.
    out_ready = 1'b0;
    send_word(8'hE0, al, rl);
    send_word(8'hE1, al, rl);
    ls_data = 8'hE2;
    ls_req  = 1'b1;
    sb.push_back(8'hE2);
    wait_ack(1'b1, al);
    chk("rst_mid_level", 32'(fifo_level), 32'd3);
    #2;
    rst = 1'b1;
    ls_req = 1'b0;
    sb.delete();
    #1;
    chk("arst_ls_ack", 32'(ls_ack), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_fifo_level", 32'(fifo_level), 32'd0);
    chk("arst_iso_abort", 32'(iso_abort), 32'd0);
    ticks(2);
    rst = 1'b0;
    ticks(1);
    out_ready = 1'b1;
    send_word(8'h77, al, rl);
    chk("post_rst_ack_lat", 32'(al), 32'd3);
    chk("post_rst_rel_lat", 32'(rl), 32'd3);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pwr_ls_handshake_receiver
